// File: rtl/gray2bin_serial.sv
// Serial Gray-to-binary decoder: one bit per clk, MSB first; result valid WIDTH edges after acceptance.
// Single transaction in flight: in_ready only in IDLE, result holds in DONE until out_ready.
module gray2bin_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             step_err,
    output logic             busy
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             step_err_q, step_err_d;

    logic [WIDTH-1:0] diff;
    logic             one_bit_step;
    logic [WIDTH-1:0] b_shr;
    logic             accept;

    assign accept = (state_q == IDLE) && in_valid;

    // Exactly one bit set: non-zero and clearing its lowest set bit leaves zero.
    assign diff         = g ^ prev_q;
    assign one_bit_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

    // The bit above idx; the shift feeds 0 at the MSB so b[MSB] = g[MSB] needs no special case.
    assign b_shr = b_q >> 1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        g_d         = g_q;
        b_d         = b_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        step_err_d  = step_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d         = g;
                    idx_d       = IDX_MSB;
                    prev_d      = g;
                    have_prev_d = 1'b1;
                    step_err_d  = have_prev_q && !one_bit_step;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                b_d[idx_q] = b_shr[idx_q] ^ g_q[idx_q];
                if (idx_q == IDX_ZERO) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            g_q         <= '0;
            b_q         <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            g_q         <= g_d;
            b_q         <= b_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            step_err_q  <= step_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = ~in_ready;
    assign b         = b_q;
    assign step_err  = step_err_q;
endmodule

// File: tb/tb_gray2bin_serial.sv
// Directed bench for gray2bin_serial at WIDTH=4 with hand-computed expected results.
module tb_gray2bin_serial;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] g = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] b;
    logic         step_err;
    logic         busy;

    int errors = 0;
    int checks = 0;

    gray2bin_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .step_err  (step_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_step_err", 32'(step_err), 32'd0);
        step();
        rst = 1'b0;
    endtask

    // Accept gin, then step to DONE, checking latency; leaves the block in DONE.
    task automatic accept_and_decode(input string tag, input logic [W-1:0] gin,
                                     input logic [W-1:0] exp_b, input logic exp_err);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        g = gin;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < W - 1; i++) step();
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_b"}, 32'(b), 32'(exp_b));
        chk({tag, "_step_err"}, 32'(step_err), 32'(exp_err));
    endtask

    // Full transaction with out_ready=1: DONE lasts one edge, then IDLE.
    task automatic txn(input string tag, input logic [W-1:0] gin,
                       input logic [W-1:0] exp_b, input logic exp_err);
        out_ready = 1'b1;
        accept_and_decode(tag, gin, exp_b, exp_err);
        step();
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1;
        do_reset();

        // Basic decode right after reset release.
        txn("t030", 4'b0110, 4'b0100, 1'b0);

        // Consecutive Gray counts 0..3.
        do_reset();
        txn("t031a", 4'b0000, 4'b0000, 1'b0);
        txn("t031b", 4'b0001, 4'b0001, 1'b0);
        txn("t031c", 4'b0011, 4'b0010, 1'b0);
        txn("t031d", 4'b0010, 4'b0011, 1'b0);

        // Two-bit jump and repeated code both flag step_err.
        do_reset();
        txn("t032a", 4'b0000, 4'b0000, 1'b0);
        txn("t032b", 4'b0011, 4'b0010, 1'b1);
        txn("t032c", 4'b0011, 4'b0010, 1'b1);

        // Wrap-around from 15 to 0 is a legal step.
        do_reset();
        txn("t033a", 4'b1000, 4'b1111, 1'b0);
        txn("t033b", 4'b0000, 4'b0000, 1'b0);

        // Backpressure in DONE with input activity that must be ignored.
        do_reset();
        out_ready = 1'b0;
        accept_and_decode("t034", 4'b0110, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            g = 4'(4'b1111 - 4'(i));
            step();
            chk("t034_hold_valid", 32'(out_valid), 32'd1);
            chk("t034_hold_b", 32'(b), 32'h4);
            chk("t034_hold_err", 32'(step_err), 32'd0);
            chk("t034_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t034_release_idle", 32'(in_ready), 32'd1);
        // prev must still be 0110; 0100 is one bit away.
        txn("t034_next", 4'b0100, 4'b0111, 1'b0);

        // Reset two edges into DECODE discards the transaction.
        do_reset();
        chk("t035_pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        g = 4'b0011;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("t035_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t035_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t035_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t035_rst_b", 32'(b), 32'd0);
        step();
        rst = 1'b0;
        txn("t035_after", 4'b0101, 4'b0110, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
